// File: rtl/id_operand_unit_pkg.sv
// rtl/id_operand_unit_pkg.sv - shared constants, branch-type encodings and immediate extension for id_operand_unit
package id_operand_unit_pkg;

  localparam int BACK_W = 38;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 16;

  // Back-bus layout: {regWrite, Wd, rw}
  localparam int BACK_WE_BIT = 37;
  localparam int BACK_WD_MSB = 36;
  localparam int BACK_WD_LSB = 5;
  localparam int BACK_RW_MSB = 4;
  localparam int BACK_RW_LSB = 0;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                input logic             extop,
                                                input logic             exsign);
    logic [DATA_W-1:0] res;
    if (extop)
      res = {imm, {(DATA_W-IMM_W){1'b0}}};
    else if (exsign)
      res = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    else
      res = {{(DATA_W-IMM_W){1'b0}}, imm};
    return res;
  endfunction

endpackage

// File: rtl/id_operand_unit_fwd_mux.sv
// rtl/id_operand_unit_fwd_mux.sv - opu_fwd_mux: forwarding select for one source operand
module opu_fwd_mux
  import id_operand_unit_pkg::*;
(
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] rd,
  input  logic [BACK_W-1:0] mem_back,
  input  logic [BACK_W-1:0] wb_back,
  input  logic              use_mem,
  input  logic              use_wb,
  output logic [DATA_W-1:0] fwd
);

  logic [REG_W-1:0]  mem_rw;
  logic [REG_W-1:0]  wb_rw;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] wb_wd;
  logic              mem_hit;
  logic              wb_hit;

  assign mem_rw = mem_back[BACK_RW_MSB:BACK_RW_LSB];
  assign wb_rw  = wb_back[BACK_RW_MSB:BACK_RW_LSB];
  assign mem_wd = mem_back[BACK_WD_MSB:BACK_WD_LSB];
  assign wb_wd  = wb_back[BACK_WD_MSB:BACK_WD_LSB];

  // A write to r0 never produces a hit, so r0 always reads the register file
  assign mem_hit = use_mem && mem_back[BACK_WE_BIT] && (mem_rw != '0) && (mem_rw == src);
  assign wb_hit  = use_wb  && wb_back[BACK_WE_BIT]  && (wb_rw  != '0) && (wb_rw  == src);

  always_comb begin
    fwd = rd;
    if (mem_hit)
      fwd = mem_wd;
    else if (wb_hit)
      fwd = wb_wd;
  end

endmodule

// File: rtl/id_operand_unit.sv
// rtl/id_operand_unit.sv - decode-stage operand forwarding, immediate extension, branch resolve and output register (ID_OPU_BRANCH_CMPZ_EN enables compare-to-zero branches)
module id_operand_unit
  import id_operand_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [BACK_W-1:0] MEM_BACK,
  input  logic [BACK_W-1:0] WB_BACK,
  input  logic              USE_MEM_BACK,
  input  logic              USE_WB_BACK,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic [IMM_W-1:0]  imm,
  input  logic              extop,
  input  logic              exsign,
  input  logic [2:0]        branchType,
  output logic [DATA_W-1:0] f_rd1,
  output logic [DATA_W-1:0] f_rd2,
  output logic [DATA_W-1:0] extb,
  output logic              branchAvail,
  output logic [DATA_W-1:0] q_rd1,
  output logic [DATA_W-1:0] q_rd2,
  output logic [DATA_W-1:0] q_ext,
  output logic              q_taken
);

  opu_fwd_mux u_fwd_rs (
    .src      (rs),
    .rd       (rd1),
    .mem_back (MEM_BACK),
    .wb_back  (WB_BACK),
    .use_mem  (USE_MEM_BACK),
    .use_wb   (USE_WB_BACK),
    .fwd      (f_rd1)
  );

  opu_fwd_mux u_fwd_rt (
    .src      (rt),
    .rd       (rd2),
    .mem_back (MEM_BACK),
    .wb_back  (WB_BACK),
    .use_mem  (USE_MEM_BACK),
    .use_wb   (USE_WB_BACK),
    .fwd      (f_rd2)
  );

  assign extb = ext_imm(imm, extop, exsign);

`ifdef ID_OPU_BRANCH_CMPZ_EN
  logic rd1_neg;
  logic rd1_zero;
  assign rd1_neg  = f_rd1[DATA_W-1];
  assign rd1_zero = (f_rd1 == '0);
`endif

  always_comb begin
    branchAvail = 1'b0;
    case (branchType)
      BR_BEQ:  branchAvail = (f_rd1 == f_rd2);
      BR_BNE:  branchAvail = (f_rd1 != f_rd2);
`ifdef ID_OPU_BRANCH_CMPZ_EN
      BR_BLEZ: branchAvail = rd1_neg || rd1_zero;
      BR_BGTZ: branchAvail = !rd1_neg && !rd1_zero;
      BR_BLTZ: branchAvail = rd1_neg;
      BR_BGEZ: branchAvail = !rd1_neg;
`endif
      default: branchAvail = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_rd1   <= '0;
      q_rd2   <= '0;
      q_ext   <= '0;
      q_taken <= 1'b0;
    end else begin
      q_rd1   <= f_rd1;
      q_rd2   <= f_rd2;
      q_ext   <= extb;
      q_taken <= branchAvail;
    end
  end

endmodule

// File: tb/tb_id_operand_unit.sv
// tb/tb_id_operand_unit.sv - self-checking bench for id_operand_unit (vector table, random model compare, register sequences)
module tb_id_operand_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [37:0] mem_back;
  logic [37:0] wb_back;
  logic        use_mem;
  logic        use_wb;
  logic [4:0]  rs, rt;
  logic [31:0] rd1, rd2;
  logic [15:0] imm;
  logic        extop, exsign;
  logic [2:0]  bt;
  logic [31:0] f_rd1, f_rd2, extb;
  logic        br;
  logic [31:0] q_rd1, q_rd2, q_ext;
  logic        q_taken;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_operand_unit dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .MEM_BACK     (mem_back),
    .WB_BACK      (wb_back),
    .USE_MEM_BACK (use_mem),
    .USE_WB_BACK  (use_wb),
    .rs           (rs),
    .rt           (rt),
    .rd1          (rd1),
    .rd2          (rd2),
    .imm          (imm),
    .extop        (extop),
    .exsign       (exsign),
    .branchType   (bt),
    .f_rd1        (f_rd1),
    .f_rd2        (f_rd2),
    .extb         (extb),
    .branchAvail  (br),
    .q_rd1        (q_rd1),
    .q_rd2        (q_rd2),
    .q_ext        (q_ext),
    .q_taken      (q_taken)
  );

  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] rd1, rd2;
    logic [37:0] mb, wb;
    logic        um, uw;
    logic [15:0] imm;
    logic        extop, exsign;
    logic [2:0]  bt;
    logic [31:0] e_f1, e_f2, e_ext;
    logic        e_br;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain rule evaluation
  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] rd,
                                        input logic [37:0] mb, input logic [37:0] wb,
                                        input logic um, input logic uw);
    if (r == 0) return rd;
    if (um && mb[37] && mb[4:0] == r) return mb[36:5];
    if (uw && wb[37] && wb[4:0] == r) return wb[36:5];
    return rd;
  endfunction

  function automatic logic [31:0] m_ext(input logic [15:0] i, input logic eo, input logic es);
    int s;
    if (eo) return 32'(i) * 32'd65536;
    if (es) begin
      s = (i >= 16'h8000) ? int'(i) - 65536 : int'(i);
      return 32'(s);
    end
    return 32'(i);
  endfunction

  function automatic logic m_br(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = a;
    case (t)
      3'd1: return a == b;
      3'd2: return a != b;
`ifdef ID_OPU_BRANCH_CMPZ_EN
      3'd3: return sa <= 0;
      3'd4: return sa > 0;
      3'd5: return sa < 0;
      3'd6: return sa >= 0;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply(input vec_t v);
    rs = v.rs; rt = v.rt; rd1 = v.rd1; rd2 = v.rd2;
    mem_back = v.mb; wb_back = v.wb; use_mem = v.um; use_wb = v.uw;
    imm = v.imm; extop = v.extop; exsign = v.exsign; bt = v.bt;
  endtask

  logic [31:0] x_f1, x_f2, x_ext;
  logic        x_br;
  logic        cmpz_exp;
  vec_t        cur;
  logic        do_flush;

  initial begin
`ifdef ID_OPU_BRANCH_CMPZ_EN
    cmpz_exp = 1'b1;
`else
    cmpz_exp = 1'b0;
`endif
    //          rs  rt  rd1           rd2           MEM_BACK                       WB_BACK                        um uw imm       eo es bt    f_rd1         f_rd2         extb          br
    vecs[0]  = '{5'd5, 5'd0, 32'h11, 32'h22, {1'b1, 32'hAAAA0000, 5'd5}, {1'b1, 32'hBBBB0000, 5'd5}, 1, 1, 16'h0000, 0, 0, 3'd0, 32'hAAAA0000, 32'h22, 32'h0, 1'b0};
    vecs[1]  = '{5'd5, 5'd0, 32'h11, 32'h22, {1'b1, 32'hAAAA0000, 5'd5}, {1'b1, 32'hBBBB0000, 5'd5}, 0, 1, 16'h0000, 0, 0, 3'd0, 32'hBBBB0000, 32'h22, 32'h0, 1'b0};
    vecs[2]  = '{5'd0, 5'd0, 32'h11, 32'h33, {1'b1, 32'h0000DEAD, 5'd0}, 38'h0, 1, 0, 16'h0000, 0, 0, 3'd0, 32'h11, 32'h33, 32'h0, 1'b0};
    vecs[3]  = '{5'd5, 5'd6, 32'h11, 32'h44, {1'b0, 32'h0000DEAD, 5'd5}, 38'h0, 1, 1, 16'h0000, 0, 0, 3'd0, 32'h11, 32'h44, 32'h0, 1'b0};
    vecs[4]  = '{5'd0, 5'd0, 32'h0, 32'h0, 38'h0, 38'h0, 0, 0, 16'h8001, 0, 1, 3'd0, 32'h0, 32'h0, 32'hFFFF8001, 1'b0};
    vecs[5]  = '{5'd0, 5'd0, 32'h0, 32'h0, 38'h0, 38'h0, 0, 0, 16'h8001, 0, 0, 3'd0, 32'h0, 32'h0, 32'h00008001, 1'b0};
    vecs[6]  = '{5'd0, 5'd0, 32'h0, 32'h0, 38'h0, 38'h0, 0, 0, 16'h8001, 1, 0, 3'd0, 32'h0, 32'h0, 32'h80010000, 1'b0};
    vecs[7]  = '{5'd1, 5'd1, 32'h7, 32'h7, 38'h0, 38'h0, 0, 0, 16'h0000, 0, 0, 3'd1, 32'h7, 32'h7, 32'h0, 1'b1};
    vecs[8]  = '{5'd1, 5'd1, 32'h7, 32'h7, 38'h0, 38'h0, 0, 0, 16'h0000, 0, 0, 3'd2, 32'h7, 32'h7, 32'h0, 1'b0};
    vecs[9]  = '{5'd1, 5'd2, 32'hFFFFFFFF, 32'h0, 38'h0, 38'h0, 0, 0, 16'h0000, 0, 0, 3'd5, 32'hFFFFFFFF, 32'h0, 32'h0, cmpz_exp};
    vecs[10] = '{5'd8, 5'd9, 32'h1, 32'h2, {1'b1, 32'h00001234, 5'd8}, {1'b1, 32'h0000CAFE, 5'd9}, 1, 1, 16'h0000, 0, 0, 3'd1, 32'h1234, 32'hCAFE, 32'h0, 1'b0};

    rst = 1'b1; flush = 1'b0;
    apply(vecs[0]);
    @(posedge clk); @(posedge clk); #1;
    check("reset_q_rd1", q_rd1, 32'h0);
    check("reset_q_rd2", q_rd2, 32'h0);
    check("reset_q_ext", q_ext, 32'h0);
    check("reset_q_taken", {31'h0, q_taken}, 32'h0);
    check("reset_comb_f_rd1", f_rd1, 32'hAAAA0000);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d_f_rd1", i), f_rd1, vecs[i].e_f1);
      check($sformatf("vec%0d_f_rd2", i), f_rd2, vecs[i].e_f2);
      check($sformatf("vec%0d_extb", i), extb, vecs[i].e_ext);
      check($sformatf("vec%0d_branch", i), {31'h0, br}, {31'h0, vecs[i].e_br});
    end

    // Capture, flush, recapture, reset, resume
    @(negedge clk);
    apply(vecs[10]); bt = 3'd2;
    @(posedge clk); #1;
    check("cap_q_rd1", q_rd1, 32'h1234);
    check("cap_q_rd2", q_rd2, 32'hCAFE);
    check("cap_q_taken", {31'h0, q_taken}, 32'h1);
    apply(vecs[6]);
    @(posedge clk); #1;
    check("cap2_q_ext", q_ext, 32'h80010000);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_q_ext", q_ext, 32'h0);
    check("flush_q_rd1", q_rd1, 32'h0);
    flush = 1'b0;
    apply(vecs[7]);
    @(posedge clk); #1;
    check("post_flush_q_rd1", q_rd1, 32'h7);
    check("post_flush_q_taken", {31'h0, q_taken}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_q_rd1", q_rd1, 32'h0);
    check("midrst_q_taken", {31'h0, q_taken}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("resume_q_rd2", q_rd2, 32'h7);

    // Random stimulus against the reference model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      cur.rs = 5'($urandom_range(0, 3));
      cur.rt = 5'($urandom_range(0, 3));
      cur.rd1 = $urandom;
      cur.rd2 = ($urandom_range(0, 3) == 0) ? cur.rd1 : $urandom;
      if ($urandom_range(0, 3) == 0) cur.rd1 = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h80000000;
      cur.mb = {1'($urandom), $urandom, 5'($urandom_range(0, 3))};
      cur.wb = {1'($urandom), $urandom, 5'($urandom_range(0, 3))};
      cur.um = 1'($urandom); cur.uw = 1'($urandom);
      cur.imm = 16'($urandom);
      cur.extop = 1'($urandom); cur.exsign = 1'($urandom);
      cur.bt = 3'($urandom);
      apply(cur);
      x_f1 = m_fwd(cur.rs, cur.rd1, cur.mb, cur.wb, cur.um, cur.uw);
      x_f2 = m_fwd(cur.rt, cur.rd2, cur.mb, cur.wb, cur.um, cur.uw);
      x_ext = m_ext(cur.imm, cur.extop, cur.exsign);
      x_br = m_br(cur.bt, x_f1, x_f2);
      do_flush = ($urandom_range(0, 7) == 0);
      flush = do_flush;
      #1;
      check("rnd_f_rd1", f_rd1, x_f1);
      check("rnd_f_rd2", f_rd2, x_f2);
      check("rnd_extb", extb, x_ext);
      check("rnd_branch", {31'h0, br}, {31'h0, x_br});
      @(posedge clk); #1;
      check("rnd_q_rd1", q_rd1, do_flush ? 32'h0 : x_f1);
      check("rnd_q_rd2", q_rd2, do_flush ? 32'h0 : x_f2);
      check("rnd_q_ext", q_ext, do_flush ? 32'h0 : x_ext);
      check("rnd_q_taken", {31'h0, q_taken}, {31'h0, do_flush ? 1'b0 : x_br});
      flush = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_operand_unit.md
ID_OPERAND_UNIT -- requirements
Module: id_operand_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for the output register stage.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 flush  input  1  clears the registered stage on the next edge.
REQ-005 MEM_BACK  input  38  {regWrite[37], Wd[36:5], rw[4:0]} from the MEM stage.
REQ-006 WB_BACK  input  38  same layout, from the WB stage.
REQ-007 USE_MEM_BACK, USE_WB_BACK  input  1 each  enable the forwarding source.
REQ-008 rs, rt  input  5 each  source register numbers.
REQ-009 rd1, rd2  input  32 each  register file read data.
REQ-010 imm  input  16  instruction immediate; extop, exsign  input  1 each.
REQ-011 branchType  input  3  branch condition select.
REQ-012 f_rd1, f_rd2  output  32  forwarded operands (combinational).
REQ-013 extb  output  32  extended immediate (combinational).
REQ-014 branchAvail  output  1  branch taken (combinational).
REQ-015 q_rd1, q_rd2, q_ext  output  32 each; q_taken  output  1  registered copies.

Function
REQ-016 Forwarding per operand: MEM source SHALL hit when USE_MEM_BACK, MEM regWrite=1, MEM rw!=0 and rw==rs (or rt); WB source likewise.
REQ-017 MEM hit SHALL take priority over WB hit; with no hit, f_rdN = rdN.
REQ-018 Register 0 SHALL never be forwarded.
REQ-019 EXT: extop=1 -> extb={imm,16'h0}; extop=0,exsign=1 -> sign-extend imm; extop=0,exsign=0 -> zero-extend imm.
REQ-020 branchType uses forwarded operands: 0 none (0); 1 beq (f_rd1==f_rd2); 2 bne (!=); 3 blez (signed f_rd1<=0); 4 bgtz (>0); 5 bltz (<0); 6 bgez (>=0); 7 reserved (0).
REQ-021 Comparisons 3-6 SHALL treat f_rd1 as 32-bit two's complement; f_rd2 is ignored.
REQ-022 Registered stage: on each rising edge, q_* SHALL capture f_rd1, f_rd2, extb, branchAvail; latency exactly 1 cycle.
REQ-023 flush=1 at an edge SHALL load all q_* with 0; rst takes priority over flush.
REQ-024 Both MEM and WB hitting the same register in the same cycle SHALL yield MEM data.

Reset
REQ-025 rst=1 at a rising edge SHALL set q_rd1, q_rd2, q_ext to 0 and q_taken to 0; combinational outputs are unaffected by reset.
REQ-026 Reset asserted mid-operation SHALL discard captured data on that edge; capture resumes on the first edge with rst=0.

Configuration
REQ-027 Macro ID_OPU_BRANCH_CMPZ_EN defined: branch types 3-6 function per REQ-020.
REQ-028 Macro undefined: only types 0-2 are decoded; types 3-7 SHALL give branchAvail=0 and no compare-to-zero logic is synthesized.

Structure
REQ-029 Shared package SHALL hold branch-type constants (BR_NONE..BR_BGEZ), back-bus field positions and widths (38-bit bus, 32-bit data, 5-bit reg).
REQ-030 One sub-module opu_fwd_mux (one operand's forwarding) SHALL be instantiated twice, for rs and rt.

Verification
REQ-031 rs=5, rd1=0x11, MEM_BACK={1,0xAAAA0000,5}, WB_BACK={1,0xBBBB0000,5}, both USE=1 -> f_rd1=0xAAAA0000; USE_MEM_BACK=0 -> 0xBBBB0000.
REQ-032 rs=0, MEM_BACK={1,0xDEAD,0} -> f_rd1=rd1; MEM regWrite=0 with matching rw -> no forward.
REQ-033 imm=0x8001: exsign=1,extop=0 -> 0xFFFF8001; exsign=0 -> 0x00008001; extop=1 -> 0x80010000.
REQ-034 branchType=1, rd1=rd2=7 -> branchAvail=1; type 2 -> 0; type 5, rd1=0xFFFFFFFF -> 1 (macro defined) / 0 (undefined).
REQ-035 Drive values, clock once -> q_* equal prior combinational values; flush=1 -> q_* all 0 next cycle; rst=1 with flush=0 -> q_* all 0.
